// File: rtl/rs_bank_if.sv
// rtl/rs_bank_if.sv - dispatch / CDB / issue bundle for the reservation-station bank
//
// Groups every handshake and bus signal of rs_bank so the bank and its driver
// share one declaration.
//   slave  : the bank side (consumes dispatch, CDB and issue_ready; produces
//            dispatch_ready, issue_* and free_count)
//   master : the dispatch/FU/CDB side, the mirror image of slave
// Packed CDB vectors carry port 0 in the least significant slice.
interface rs_bank_if #(
  parameter int NUM_ENTRIES = 8,
  parameter int CDB_WIDTH   = 2,
  parameter int TAG_W       = 5,
  parameter int DATA_W      = 32,
  parameter int PAYLOAD_W   = 64
);
  localparam int CNT_W = $clog2(NUM_ENTRIES) + 1;

  logic                        dispatch_valid;
  logic                        dispatch_ready;
  logic [PAYLOAD_W-1:0]        dispatch_payload;
  logic                        dispatch_rs1_rdy;
  logic [TAG_W-1:0]            dispatch_rs1_tag;
  logic [DATA_W-1:0]           dispatch_rs1_value;
  logic                        dispatch_rs2_rdy;
  logic [TAG_W-1:0]            dispatch_rs2_tag;
  logic [DATA_W-1:0]           dispatch_rs2_value;

  logic [CDB_WIDTH-1:0]        cdb_valid;
  logic [CDB_WIDTH*TAG_W-1:0]  cdb_tag;
  logic [CDB_WIDTH*DATA_W-1:0] cdb_value;

  logic                        issue_valid;
  logic                        issue_ready;
  logic [PAYLOAD_W-1:0]        issue_payload;
  logic [DATA_W-1:0]           issue_rs1_value;
  logic [DATA_W-1:0]           issue_rs2_value;

  logic [CNT_W-1:0]            free_count;

  modport slave (
    input  dispatch_valid, dispatch_payload,
    input  dispatch_rs1_rdy, dispatch_rs1_tag, dispatch_rs1_value,
    input  dispatch_rs2_rdy, dispatch_rs2_tag, dispatch_rs2_value,
    input  cdb_valid, cdb_tag, cdb_value,
    input  issue_ready,
    output dispatch_ready,
    output issue_valid, issue_payload, issue_rs1_value, issue_rs2_value,
    output free_count
  );

  modport master (
    output dispatch_valid, dispatch_payload,
    output dispatch_rs1_rdy, dispatch_rs1_tag, dispatch_rs1_value,
    output dispatch_rs2_rdy, dispatch_rs2_tag, dispatch_rs2_value,
    output cdb_valid, cdb_tag, cdb_value,
    output issue_ready,
    input  dispatch_ready,
    input  issue_valid, issue_payload, issue_rs1_value, issue_rs2_value,
    input  free_count
  );
endinterface

// File: rtl/rs_bank.sv
// rtl/rs_bank.sv - multi-entry reservation-station bank with age-matrix select
//
// Holds NUM_ENTRIES instructions between dispatch and issue, snoops CDB_WIDTH
// broadcast ports every cycle and issues the oldest ready entry to one FU.
// Ports:
//   clock  : rising-edge clock
//   reset  : asynchronous active-high reset
//   squash : synchronous flush of every entry
//   bus    : rs_bank_if.slave (dispatch request, CDB snoop, issue handshake,
//            free_count)
module rs_bank #(
  parameter int NUM_ENTRIES = 8,
  parameter int CDB_WIDTH   = 2,
  parameter int TAG_W       = 5,
  parameter int DATA_W      = 32,
  parameter int PAYLOAD_W   = 64
) (
  input logic     clock,
  input logic     reset,
  input logic     squash,
  rs_bank_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_ENTRIES);
  localparam int CNT_W = IDX_W + 1;

  typedef struct packed {
    logic              hit;
    logic [DATA_W-1:0] value;
  } snoop_t;

  // Lowest matching port wins when a tag is (illegally) broadcast twice.
  function automatic snoop_t snoop(
    input logic [TAG_W-1:0]            tag,
    input logic [CDB_WIDTH-1:0]        valid,
    input logic [CDB_WIDTH*TAG_W-1:0]  tags,
    input logic [CDB_WIDTH*DATA_W-1:0] values
  );
    snoop_t r;
    r = '0;
    for (int p = CDB_WIDTH - 1; p >= 0; p--) begin
      if (valid[p] && (tags[p*TAG_W +: TAG_W] == tag)) begin
        r.hit   = 1'b1;
        r.value = values[p*DATA_W +: DATA_W];
      end
    end
    return r;
  endfunction

  // Entry state
  logic [NUM_ENTRIES-1:0] busy;
  logic [NUM_ENTRIES-1:0] rdy1;
  logic [NUM_ENTRIES-1:0] rdy2;
  logic [TAG_W-1:0]       tag1    [NUM_ENTRIES];
  logic [TAG_W-1:0]       tag2    [NUM_ENTRIES];
  logic [DATA_W-1:0]      val1    [NUM_ENTRIES];
  logic [DATA_W-1:0]      val2    [NUM_ENTRIES];
  logic [PAYLOAD_W-1:0]   payload [NUM_ENTRIES];
  // older[j][k] = 1: entry j was dispatched before entry k
  logic [NUM_ENTRIES-1:0] older   [NUM_ENTRIES];
  logic [CNT_W-1:0]       free_cnt;

  // Per-entry wakeup view of this cycle
  snoop_t                 s1 [NUM_ENTRIES];
  snoop_t                 s2 [NUM_ENTRIES];
  logic [DATA_W-1:0]      val1_now [NUM_ENTRIES];
  logic [DATA_W-1:0]      val2_now [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] entry_ready;
  logic [NUM_ENTRIES-1:0] grant;
  logic [IDX_W-1:0]       sel_idx;
  logic                   sel_any;
  logic [IDX_W-1:0]       alloc_idx;
  snoop_t                 d1;
  snoop_t                 d2;
  logic                   dispatch_fire;
  logic                   issue_fire;
  logic [NUM_ENTRIES-1:0] busy_next;
  logic [CNT_W-1:0]       free_next;

  always_comb begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      s1[i] = snoop(tag1[i], bus.cdb_valid, bus.cdb_tag, bus.cdb_value);
      s2[i] = snoop(tag2[i], bus.cdb_valid, bus.cdb_tag, bus.cdb_value);
      val1_now[i] = rdy1[i] ? val1[i] : s1[i].value;
      val2_now[i] = rdy2[i] ? val2[i] : s2[i].value;
      entry_ready[i] = busy[i] && (rdy1[i] || s1[i].hit) && (rdy2[i] || s2[i].hit);
    end
  end

  // An entry wins when no other ready entry is older than it. The diagonal of
  // the matrix is always 0, so the column can be used unmasked.
  always_comb begin
    logic [NUM_ENTRIES-1:0] col;
    col = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      for (int j = 0; j < NUM_ENTRIES; j++) begin
        col[j] = older[j][i];
      end
      grant[i] = entry_ready[i] && ((col & entry_ready) == '0);
    end
  end

  // Priority encoders: the grant vector is one-hot for a consistent matrix;
  // the encoder just keeps the select well defined regardless.
  always_comb begin
    sel_idx   = '0;
    sel_any   = 1'b0;
    alloc_idx = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (grant[i]) begin
        sel_idx = IDX_W'(i);
        sel_any = 1'b1;
      end
      if (!busy[i]) begin
        alloc_idx = IDX_W'(i);
      end
    end
  end

  assign bus.dispatch_ready  = (free_cnt != '0);
  assign bus.free_count      = free_cnt;
  assign bus.issue_valid     = sel_any && !squash;
  assign bus.issue_payload   = sel_any ? payload[sel_idx]  : '0;
  assign bus.issue_rs1_value = sel_any ? val1_now[sel_idx] : '0;
  assign bus.issue_rs2_value = sel_any ? val2_now[sel_idx] : '0;

  assign dispatch_fire = bus.dispatch_valid && bus.dispatch_ready && !squash;
  assign issue_fire    = bus.issue_valid && bus.issue_ready;

  // Dispatch-time CDB capture of operands that are still pending
  always_comb begin
    d1 = snoop(bus.dispatch_rs1_tag, bus.cdb_valid, bus.cdb_tag, bus.cdb_value);
    d2 = snoop(bus.dispatch_rs2_tag, bus.cdb_valid, bus.cdb_tag, bus.cdb_value);
  end

  always_comb begin
    busy_next = busy;
    if (squash) begin
      busy_next = '0;
    end else begin
      if (issue_fire)    busy_next[sel_idx]   = 1'b0;
      if (dispatch_fire) busy_next[alloc_idx] = 1'b1;
    end
    free_next = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (!busy_next[i]) free_next = free_next + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy     <= '0;
      rdy1     <= '0;
      rdy2     <= '0;
      free_cnt <= CNT_W'(NUM_ENTRIES);
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        tag1[i]    <= '0;
        tag2[i]    <= '0;
        val1[i]    <= '0;
        val2[i]    <= '0;
        payload[i] <= '0;
        older[i]   <= '0;
      end
    end else begin
      busy     <= busy_next;
      free_cnt <= free_next;
      for (int k = 0; k < NUM_ENTRIES; k++) begin
        if (dispatch_fire && (alloc_idx == IDX_W'(k))) begin
          payload[k] <= bus.dispatch_payload;
          tag1[k]    <= bus.dispatch_rs1_tag;
          tag2[k]    <= bus.dispatch_rs2_tag;
          if (!bus.dispatch_rs1_rdy && d1.hit) begin
            rdy1[k] <= 1'b1;
            val1[k] <= d1.value;
          end else begin
            rdy1[k] <= bus.dispatch_rs1_rdy;
            val1[k] <= bus.dispatch_rs1_value;
          end
          if (!bus.dispatch_rs2_rdy && d2.hit) begin
            rdy2[k] <= 1'b1;
            val2[k] <= d2.value;
          end else begin
            rdy2[k] <= bus.dispatch_rs2_rdy;
            val2[k] <= bus.dispatch_rs2_value;
          end
          // New entry is younger than every live entry and older than none.
          older[k] <= '0;
          for (int j = 0; j < NUM_ENTRIES; j++) begin
            if (j != k) older[j][k] <= busy[j];
          end
        end else if (busy[k]) begin
          if (!rdy1[k] && s1[k].hit) begin
            rdy1[k] <= 1'b1;
            val1[k] <= s1[k].value;
          end
          if (!rdy2[k] && s2[k].hit) begin
            rdy2[k] <= 1'b1;
            val2[k] <= s2[k].value;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_rs_bank.sv
// tb/tb_rs_bank.sv - scoreboard bench for rs_bank against an in-order queue model
module tb_rs_bank;
  localparam int N  = 8;
  localparam int CW = 2;
  localparam int TW = 5;
  localparam int DW = 32;
  localparam int PW = 64;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic squash = 1'b0;
  always #5 clock = ~clock;

  rs_bank_if #(.NUM_ENTRIES(N), .CDB_WIDTH(CW), .TAG_W(TW), .DATA_W(DW), .PAYLOAD_W(PW)) bus ();

  rs_bank #(.NUM_ENTRIES(N), .CDB_WIDTH(CW), .TAG_W(TW), .DATA_W(DW), .PAYLOAD_W(PW)) dut (
    .clock (clock),
    .reset (reset),
    .squash(squash),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model: live instructions in dispatch order (front = oldest)
  typedef struct {
    logic [PW-1:0] pl;
    bit            r1;
    logic [TW-1:0] t1;
    logic [DW-1:0] v1;
    bit            r2;
    logic [TW-1:0] t2;
    logic [DW-1:0] v2;
  } ent_t;
  typedef struct {
    logic [PW-1:0] pl;
    logic [DW-1:0] v1;
    logic [DW-1:0] v2;
  } iss_t;
  typedef struct {
    bit iv;
    bit dr;
    int fc;
  } cyc_t;

  ent_t mq[$];
  iss_t iss_q[$];
  cyc_t cyc_q[$];

  // Stimulus for the next cycle
  bit            s_dv, s_r1, s_r2, s_ir, s_sq;
  logic [PW-1:0] s_pl;
  logic [TW-1:0] s_t1, s_t2;
  logic [DW-1:0] s_v1, s_v2;
  bit            s_cv   [CW];
  logic [TW-1:0] s_ct   [CW];
  logic [DW-1:0] s_cval [CW];

  function automatic bit cdb_hit(input logic [TW-1:0] t, output logic [DW-1:0] v);
    v = '0;
    for (int p = 0; p < CW; p++) begin
      if (s_cv[p] && s_ct[p] == t) begin
        v = s_cval[p];
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  function automatic bit operand(input bit r, input logic [TW-1:0] t, input logic [DW-1:0] v_in,
                                 output logic [DW-1:0] v);
    if (r) begin
      v = v_in;
      return 1'b1;
    end
    return cdb_hit(t, v);
  endfunction

  task automatic model();
    cyc_t c;
    int   found;
    bit   can_disp;
    logic [DW-1:0] a, b;
    c.fc = N - mq.size();
    c.dr = (mq.size() < N);
    found = -1;
    for (int k = 0; k < mq.size(); k++) begin
      if (operand(mq[k].r1, mq[k].t1, mq[k].v1, a) && operand(mq[k].r2, mq[k].t2, mq[k].v2, b)) begin
        found = k;
        break;
      end
    end
    c.iv = !s_sq && (found >= 0);
    cyc_q.push_back(c);
    if (s_sq) begin
      mq.delete();
    end else begin
      can_disp = s_dv && (mq.size() < N);
      if (c.iv && s_ir) begin
        iss_t e;
        void'(operand(mq[found].r1, mq[found].t1, mq[found].v1, e.v1));
        void'(operand(mq[found].r2, mq[found].t2, mq[found].v2, e.v2));
        e.pl = mq[found].pl;
        iss_q.push_back(e);
        mq.delete(found);
      end
      for (int k = 0; k < mq.size(); k++) begin
        if (!mq[k].r1 && cdb_hit(mq[k].t1, a)) begin mq[k].r1 = 1; mq[k].v1 = a; end
        if (!mq[k].r2 && cdb_hit(mq[k].t2, b)) begin mq[k].r2 = 1; mq[k].v2 = b; end
      end
      if (can_disp) begin
        ent_t n;
        n.pl = s_pl; n.t1 = s_t1; n.t2 = s_t2;
        n.r1 = s_r1; n.v1 = s_v1; n.r2 = s_r2; n.v2 = s_v2;
        if (!s_r1 && cdb_hit(s_t1, a)) begin n.r1 = 1; n.v1 = a; end
        if (!s_r2 && cdb_hit(s_t2, b)) begin n.r2 = 1; n.v2 = b; end
        mq.push_back(n);
      end
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    bus.dispatch_valid     = s_dv;
    bus.dispatch_payload   = s_pl;
    bus.dispatch_rs1_rdy   = s_r1;
    bus.dispatch_rs1_tag   = s_t1;
    bus.dispatch_rs1_value = s_v1;
    bus.dispatch_rs2_rdy   = s_r2;
    bus.dispatch_rs2_tag   = s_t2;
    bus.dispatch_rs2_value = s_v2;
    for (int p = 0; p < CW; p++) begin
      bus.cdb_valid[p]            = s_cv[p];
      bus.cdb_tag[p*TW +: TW]     = s_ct[p];
      bus.cdb_value[p*DW +: DW]   = s_cval[p];
    end
    bus.issue_ready = s_ir;
    squash          = s_sq;
    model();
  endtask

  task automatic idle_in(input bit ir);
    s_dv = 0; s_sq = 0; s_ir = ir;
    s_pl = '0; s_r1 = 0; s_t1 = '0; s_v1 = '0; s_r2 = 0; s_t2 = '0; s_v2 = '0;
    for (int p = 0; p < CW; p++) begin
      s_cv[p] = 0; s_ct[p] = '0; s_cval[p] = '0;
    end
  endtask

  task automatic disp(input logic [PW-1:0] pl, input bit r1, input logic [TW-1:0] t1,
                      input logic [DW-1:0] v1, input bit r2, input logic [TW-1:0] t2,
                      input logic [DW-1:0] v2);
    s_dv = 1; s_pl = pl;
    s_r1 = r1; s_t1 = t1; s_v1 = v1;
    s_r2 = r2; s_t2 = t2; s_v2 = v2;
  endtask

  // Monitor: pops the per-cycle expectation and, on every accepted issue,
  // the next expected issued instruction.
  initial begin
    cyc_t c;
    iss_t e;
    forever begin
      @(negedge clock);
      if (cyc_q.size() > 0) begin
        c = cyc_q.pop_front();
        chk("issue_valid", 64'(bus.issue_valid), 64'(c.iv));
        chk("dispatch_ready", 64'(bus.dispatch_ready), 64'(c.dr));
        chk("free_count", 64'(bus.free_count), 64'(c.fc));
        if (bus.issue_valid && bus.issue_ready) begin
          if (iss_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_issue actual=%h required=none", bus.issue_payload);
          end else begin
            e = iss_q.pop_front();
            chk("issue_payload", bus.issue_payload, e.pl);
            chk("issue_rs1_value", 64'(bus.issue_rs1_value), 64'(e.v1));
            chk("issue_rs2_value", 64'(bus.issue_rs2_value), 64'(e.v2));
          end
        end
      end
    end
  end

  initial begin
    idle_in(0);
    bus.dispatch_valid = 0; bus.dispatch_payload = '0;
    bus.dispatch_rs1_rdy = 0; bus.dispatch_rs1_tag = '0; bus.dispatch_rs1_value = '0;
    bus.dispatch_rs2_rdy = 0; bus.dispatch_rs2_tag = '0; bus.dispatch_rs2_value = '0;
    bus.cdb_valid = '0; bus.cdb_tag = '0; bus.cdb_value = '0; bus.issue_ready = 0;
    #23;
    chk("reset_issue_valid", 64'(bus.issue_valid), 64'd0);
    chk("reset_dispatch_ready", 64'(bus.dispatch_ready), 64'd1);
    chk("reset_free_count", 64'(bus.free_count), 64'd8);
    chk("reset_issue_payload", bus.issue_payload, 64'd0);
    reset = 0;

    // Idle after reset
    idle_in(1); step(); step();

    // Both operands ready, issued the next cycle, slot back one cycle later
    disp(64'h100, 1, 0, 5, 1, 0, 7); step();
    idle_in(1); step(); step();

    // A waits on tag 3, B ready; FU always ready: B goes before the broadcast
    idle_in(1); disp(64'hA1, 0, 3, 0, 1, 0, 2); step();
    idle_in(1); disp(64'hB1, 1, 0, 9, 1, 0, 8); step();
    idle_in(1); step();
    idle_in(1); s_cv[1] = 1; s_ct[1] = 3; s_cval[1] = 32'hAA; step();
    idle_in(1); step();

    // Same, but B held until the broadcast: A is older and takes the bypass
    idle_in(0); disp(64'hA2, 0, 3, 0, 1, 0, 2); step();
    idle_in(0); disp(64'hB2, 1, 0, 9, 1, 0, 8); step();
    idle_in(0); step();
    idle_in(1); s_cv[1] = 1; s_ct[1] = 3; s_cval[1] = 32'hAA; step();
    idle_in(1); step(); step();

    // Dispatch-time capture on rs2 from port 0
    idle_in(1); disp(64'hC0, 1, 0, 32'h11, 0, 9, 0);
    s_cv[0] = 1; s_ct[0] = 9; s_cval[0] = 32'h1234; step();
    idle_in(1); step(); step();

    // Fill the bank with waiting entries, ninth dispatch is dropped
    for (int k = 0; k < 9; k++) begin
      idle_in(1); disp(64'hF00 + 64'(k), 0, TW'(10 + k), 0, 1, 0, 32'(k)); step();
    end
    idle_in(1); s_cv[0] = 1; s_ct[0] = 15; s_cval[0] = 32'h55; step();
    idle_in(1); step(); step();

    // Squash with a dispatch in the same cycle
    idle_in(1); s_sq = 1; step();
    for (int k = 0; k < 4; k++) begin
      idle_in(1); disp(64'hD00 + 64'(k), 0, TW'(20 + k), 0, 1, 0, 0); step();
    end
    idle_in(1); s_sq = 1; disp(64'hDEAD, 1, 0, 1, 1, 0, 2); step();
    idle_in(1); step(); step();

    // Asynchronous reset mid-cycle while an entry is presented
    idle_in(0); disp(64'hE0, 1, 0, 3, 1, 0, 4); step();
    idle_in(0); step();
    @(negedge clock);
    #1;
    chk("pre_reset_issue_valid", 64'(bus.issue_valid), 64'd1);
    reset = 1;
    #1;
    chk("async_reset_issue_valid", 64'(bus.issue_valid), 64'd0);
    chk("async_reset_free_count", 64'(bus.free_count), 64'd8);
    chk("async_reset_dispatch_ready", 64'(bus.dispatch_ready), 64'd1);
    mq.delete();
    @(posedge clock);
    #1;
    reset = 0;

    // Randomized traffic over a small tag space so wakeups are frequent
    for (int cyc = 0; cyc < 3000; cyc++) begin
      idle_in($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 9) < 6) begin
        disp({32'(cyc), $urandom()}, $urandom_range(0, 1) == 1, TW'($urandom_range(0, 7)), $urandom(),
             $urandom_range(0, 1) == 1, TW'($urandom_range(0, 7)), $urandom());
      end
      for (int p = 0; p < CW; p++) begin
        s_cv[p]   = $urandom_range(0, 1) == 1;
        s_ct[p]   = TW'($urandom_range(0, 7));
        s_cval[p] = $urandom();
      end
      s_sq = ($urandom_range(0, 49) == 0);
      step();
    end

    idle_in(0); step(); step();
    @(negedge clock);
    #1;
    chk("scoreboard_issue_drained", 64'(iss_q.size()), 64'd0);
    chk("scoreboard_cycle_drained", 64'(cyc_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rs_bank.md
Name: rs_bank

Overview:
- Parametrised reservation-station bank; successor to the single-entry RS slot.
- Holds NUM_ENTRIES instructions between dispatch and issue.
- Snoops CDB_WIDTH broadcast ports per cycle, with same-cycle CDB bypass on both dispatch and issue.
- Selects the oldest ready entry through an age matrix and issues it over a valid/ready handshake to one functional-unit channel.

Parameters:
NUM_ENTRIES, 8, number of RS entries (>=2)
CDB_WIDTH, 2, number of CDB broadcast ports snooped per cycle
TAG_W, 5, ROB tag width
DATA_W, 32, operand value width
PAYLOAD_W, 64, opaque decoded-instruction payload width (carried through untouched)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous active-high reset
squash  in  1  synchronous flush of all entries (branch mispredict)
dispatch_valid  in  1  dispatch request this cycle
dispatch_ready  out  1  bank has a free entry (registered-state based)
dispatch_payload  in  PAYLOAD_W  decoded instruction fields
dispatch_rs1_rdy  in  1  rs1 value valid at dispatch
dispatch_rs1_tag  in  TAG_W  producer tag when rs1 not ready
dispatch_rs1_value  in  DATA_W  rs1 value when ready
dispatch_rs2_rdy / dispatch_rs2_tag / dispatch_rs2_value  in  1/TAG_W/DATA_W  same for rs2
cdb_valid  in  CDB_WIDTH  per-port broadcast valid
cdb_tag  in  CDB_WIDTH*TAG_W  packed tags, port 0 in LSBs
cdb_value  in  CDB_WIDTH*DATA_W  packed values, port 0 in LSBs
issue_valid  out  1  an entry is selected for issue
issue_ready  in  1  FU accepts issue this cycle
issue_payload  out  PAYLOAD_W  payload of selected entry
issue_rs1_value / issue_rs2_value  out  DATA_W  operands (CDB-bypassed)
free_count  out  $clog2(NUM_ENTRIES)+1  number of non-busy entries

Behaviour:
- Reset (async, reset high): all busy bits, operand ready bits, tags, values, payloads and the age matrix cleared to 0. Outputs during and after reset: issue_valid=0, dispatch_ready=1, free_count=NUM_ENTRIES, issue_* data=0.
- Per-entry state: busy, payload, rdy1/tag1/val1, rdy2/tag2/val2.
- Dispatch:
  - Fires when dispatch_valid && dispatch_ready && !squash.
  - Writes the lowest-index non-busy entry; busy set at the next edge.
  - dispatch_ready = (free_count != 0), computed from registered busy bits only; a same-cycle issue does not free a slot for the same-cycle dispatch.
  - Dispatch-time CDB capture: if operand rdy=0 and a cdb port has valid && tag match, the operand is stored ready with that port's value. Otherwise rdy/tag/value are stored as given.
- Wakeup:
  - Each busy entry with rdy=0 compares its tag against every valid CDB port every cycle.
  - On match, next state is rdy=1 and val=matching port value.
  - If more than one port matches (illegal duplicate broadcast), the lowest port index wins.
- Ready:
  - entry_ready[i] = busy[i] && (rdy1 || cdb hit on tag1) && (rdy2 || cdb hit on tag2).
  - Operands woken this cycle are bypassed combinationally to the issue_* outputs, so an entry waiting on a tag issues in the same cycle the tag broadcasts.
  - An entry being dispatched this cycle is not ready until the next cycle.
- Age matrix:
  - older[j][k]=1 means entry j was dispatched before entry k.
  - On dispatch into k: older[j][k]=busy[j] for all j≠k, and older[k][j]=0.
  - Rows and columns of freed entries are don't-care, masked by busy.
- Select: the oldest ready entry i, i.e. the one with no ready j where older[j][i]=1.
- Issue handshake:
  - issue_valid = |entry_ready && !squash; it is combinational and may change while issue_ready is low.
  - On issue_valid && issue_ready, the selected entry's busy clears at the next edge.
  - issue_ready low: nothing is freed; entries keep snooping the CDB.
- free_count: registered popcount of !busy, updated each edge.
- Squash:
  - At the next edge all busy clear and free_count becomes NUM_ENTRIES.
  - A dispatch and issue presented in the squash cycle are both dropped; issue_valid is already 0.
  - squash and reset together: reset dominates.
- Full bank (free_count=0): dispatch_ready=0 and dispatch_valid is ignored. Issue and dispatch in the same cycle while full: the issue is accepted, the dispatch is not.

Test Plan:
- Reset then idle -> issue_valid=0, dispatch_ready=1, free_count=8.
- Dispatch with both operands ready (rs1=5, rs2=7), issue_ready=1 -> issue_valid=1 the next cycle with values 5/7; free_count returns to 8 one cycle later.
- Dispatch A (rs1 tag 3 pending), then B (ready), then cdb port1 broadcasts tag 3 with value 0xAA:
  - Broadcast cycle: B issues first, since A is not ready until the broadcast.
  - If B is held (issue_ready=0) until the broadcast, A issues first as the older entry, with rs1=0xAA bypassed in that cycle.
- Dispatch with rs2 tag 9 while cdb port0 broadcasts tag 9 / value 0x1234 in the same cycle -> the entry stores rs2 ready, is ready the next cycle, and issues rs2=0x1234.
- Fill all 8 entries with unready operands -> dispatch_ready=0 and a 9th dispatch is dropped. Then broadcast to wake entry 5 with issue_ready=1 -> entry 5 issues and dispatch_ready=1 the cycle after.
- 4 busy entries, assert squash alongside dispatch_valid=1 -> free_count=8 the next cycle, nothing issues. Then assert async reset mid-cycle -> issue_valid drops immediately.
